// File: rtl/wavetable_voice_reader.sv
// Time-multiplexed wavetable reader: one ROM serves CHANNELS voices through a
// 3-stage pipeline, with per-frame snapshot, loop wrap, muting and atomic commit.
module wavetable_voice_reader #(
  parameter int    CHANNELS   = 16,
  parameter int    INSTR_W    = 7,
  parameter int    PTR_W      = 10,
  parameter int    ADDR_W     = 17,
  parameter int    SAMPLE_W   = 8,
  parameter int    OUT_W      = 12,
  parameter int    DEPTH      = 68392,
  parameter bit    SIGNED_OUT = 1'b0,
  parameter string WAVE_FILE  = "Roland_Waves_mem.txt",
  parameter string TABLE_FILE = "instr_table.txt"
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         TICK,
  input  logic [CHANNELS*INSTR_W-1:0]  INSTR,
  input  logic [CHANNELS*PTR_W-1:0]    PTR,
  input  logic [CHANNELS-1:0]          MUTE,
  output logic [CHANNELS*OUT_W-1:0]    VALUES,
  output logic                         BUSY,
  output logic                         DONE,
  output logic                         OVERRUN
);

  localparam int CNT_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int LEN_W = PTR_W + 1;
  localparam int TBL_W = ADDR_W + LEN_W;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, COMMIT = 2'd3} state_t;

  logic [SAMPLE_W-1:0] wave_rom  [DEPTH];
  logic [TBL_W-1:0]    instr_rom [2**INSTR_W];

  state_t                      state_r, state_s;
  logic [CNT_W-1:0]            cnt_r, cnt_s;
  logic                        accept_s;
  logic [CHANNELS*INSTR_W-1:0] snap_instr_r;
  logic [CHANNELS*PTR_W-1:0]   snap_ptr_r;
  logic [CHANNELS-1:0]         snap_mute_r;

  logic                s0_vld_r, s0_mute_r;
  logic [CNT_W-1:0]    s0_ch_r;
  logic [TBL_W-1:0]    s0_tbl_r;
  logic [PTR_W-1:0]    s0_ptr_r;

  logic [LEN_W-1:0]    len_s;
  logic [ADDR_W-1:0]   base_s, addr_s, rd_addr_s;
  logic [PTR_W+1:0]    p_ext_s, len_ext_s, idx_s;
  logic                in_loop_s, silence_s;

  logic                s1_vld_r, s1_sil_r;
  logic [CNT_W-1:0]    s1_ch_r;
  logic [SAMPLE_W-1:0] s1_data_r;

  logic [OUT_W-1:0]    shadow_r [CHANNELS];

  function automatic logic [OUT_W-1:0] fmt(input logic [SAMPLE_W-1:0] s);
    logic [OUT_W-1:0] r;
    if (SIGNED_OUT) begin
      r = OUT_W'({~s[SAMPLE_W-1], s[SAMPLE_W-2:0]}) << (OUT_W - SAMPLE_W);
    end else begin
      r = OUT_W'(s);
    end
    return r;
  endfunction

  // Frame state register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Frame sequencing; the counter paces both channel issue and pipeline drain
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    accept_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (TICK && !BUSY) begin
          accept_s = 1'b1;
          cnt_s    = '0;
          state_s  = RUN;
        end else begin
          state_s  = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == CNT_W'(CHANNELS - 1)) begin
          cnt_s   = '0;
          state_s = DRAIN;
        end else begin
          cnt_s   = cnt_r + 1'b1;
        end
      end
      DRAIN: begin
        if (cnt_r == CNT_W'(1)) begin
          cnt_s   = '0;
          state_s = COMMIT;
        end else begin
          cnt_s   = cnt_r + 1'b1;
        end
      end
      COMMIT:  state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Snapshot of voice inputs taken on the accepted tick
  always_ff @(posedge CLK) begin
    if (RST) begin
      snap_instr_r <= '0;
      snap_ptr_r   <= '0;
      snap_mute_r  <= '0;
    end else if (accept_s) begin
      snap_instr_r <= INSTR;
      snap_ptr_r   <= PTR;
      snap_mute_r  <= MUTE;
    end
  end

  // Stage 0: instrument table lookup
  always_ff @(posedge CLK) begin
    if (RST) begin
      s0_vld_r <= 1'b0;
    end else begin
      s0_vld_r <= (state_r == RUN);
    end
    s0_ch_r   <= cnt_r;
    s0_tbl_r  <= instr_rom[snap_instr_r[cnt_r*INSTR_W +: INSTR_W]];
    s0_ptr_r  <= snap_ptr_r[cnt_r*PTR_W +: PTR_W];
    s0_mute_r <= snap_mute_r[cnt_r];
  end

  // Single-subtract loop wrap; pointers beyond two loop lengths are silenced
  always_comb begin
    len_s     = s0_tbl_r[LEN_W-1:0];
    base_s    = s0_tbl_r[TBL_W-1 -: ADDR_W];
    p_ext_s   = {2'b00, s0_ptr_r};
    len_ext_s = {1'b0, len_s};
    if (p_ext_s < len_ext_s) begin
      idx_s     = p_ext_s;
      in_loop_s = 1'b1;
    end else if (p_ext_s < {len_s, 1'b0}) begin
      idx_s     = p_ext_s - len_ext_s;
      in_loop_s = 1'b1;
    end else begin
      idx_s     = '0;
      in_loop_s = 1'b0;
    end
    addr_s    = base_s + ADDR_W'(idx_s);
    silence_s = !in_loop_s || ({1'b0, addr_s} >= DEPTH_L) || s0_mute_r || (len_s == '0);
    rd_addr_s = silence_s ? '0 : addr_s;
  end

  // Stage 1: wavetable read
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_vld_r <= 1'b0;
    end else begin
      s1_vld_r <= s0_vld_r;
    end
    s1_ch_r   <= s0_ch_r;
    s1_sil_r  <= silence_s;
    s1_data_r <= wave_rom[rd_addr_s];
  end

  // Stage 2: format conversion into the shadow buffer
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int k = 0; k < CHANNELS; k++) shadow_r[k] <= '0;
    end else if (s1_vld_r) begin
      shadow_r[s1_ch_r] <= s1_sil_r ? '0 : fmt(s1_data_r);
    end
  end

  // Registered outputs: atomic commit, busy window and sticky overrun
  always_ff @(posedge CLK) begin
    if (RST) begin
      VALUES  <= '0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      OVERRUN <= 1'b0;
    end else begin
      DONE    <= (state_r == COMMIT);
      OVERRUN <= OVERRUN | (TICK & BUSY);
      if (state_r == COMMIT) begin
        for (int k = 0; k < CHANNELS; k++) VALUES[k*OUT_W +: OUT_W] <= shadow_r[k];
      end
      if (accept_s) begin
        BUSY <= 1'b1;
      end else if (DONE) begin
        BUSY <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wavetable_voice_reader.sv
// Self-checking bench for wavetable_voice_reader: directed vector table plus
// randomized frames checked against an arithmetic reference model.
module tb_wavetable_voice_reader;

  localparam int CH    = 16;
  localparam int IW    = 7;
  localparam int PW    = 10;
  localparam int OW    = 12;
  localparam int DEPTH = 68392;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              TICK = 1'b0;
  logic [CH*IW-1:0]  INSTR = '0;
  logic [CH*PW-1:0]  PTR = '0;
  logic [CH-1:0]     MUTE = '0;
  logic [CH*OW-1:0]  VALUES;
  logic              BUSY, DONE, OVERRUN;

  wavetable_voice_reader dut (
    .CLK(CLK), .RST(RST), .TICK(TICK), .INSTR(INSTR), .PTR(PTR), .MUTE(MUTE),
    .VALUES(VALUES), .BUSY(BUSY), .DONE(DONE), .OVERRUN(OVERRUN)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         ch;
    int         instr;
    int         ptr;
    bit         mute;
    logic [11:0] exp;
  } vec_t;

  logic [7:0] m_wave [DEPTH];
  int         m_base [128];
  int         m_len  [128];
  int         f_instr [CH];
  int         f_ptr   [CH];
  bit         f_mute  [CH];
  logic [11:0] exp_v  [CH];
  int         n_tests = 0;
  int         n_fail  = 0;
  vec_t       vecs [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] model(input int instr, input int ptr, input bit mute);
    int len, idx, addr;
    len = m_len[instr];
    if (mute || len == 0) return 12'h000;
    if (ptr < len) idx = ptr;
    else if (ptr < 2 * len) idx = ptr - len;
    else return 12'h000;
    addr = (m_base[instr] + idx) % 131072;
    if (addr >= DEPTH) return 12'h000;
    return {4'h0, m_wave[addr]};
  endfunction

  task automatic set_wave(input int a, input logic [7:0] v);
    m_wave[a] = v;
    dut.wave_rom[a] = v;
  endtask

  task automatic set_instr(input int i, input int base, input int len);
    m_base[i] = base;
    m_len[i]  = len;
    dut.instr_rom[i] = {17'(base), 11'(len)};
  endtask

  task automatic drive_inputs();
    for (int k = 0; k < CH; k++) begin
      INSTR[k*IW +: IW] = 7'(f_instr[k]);
      PTR[k*PW +: PW]   = 10'(f_ptr[k]);
      MUTE[k]           = f_mute[k];
    end
  endtask

  task automatic random_frame();
    for (int k = 0; k < CH; k++) begin
      f_instr[k] = $urandom_range(0, 127);
      f_ptr[k]   = $urandom_range(0, 1023);
      f_mute[k]  = ($urandom_range(0, 7) == 0);
      exp_v[k]   = model(f_instr[k], f_ptr[k], f_mute[k]);
    end
  endtask

  // Tick, then run up to ncyc cycles; cycle c ends at the c-th edge after the accepted one.
  task automatic run_frame(input int ncyc, input bit stop_on_done, input int chg_at,
                           input int tick2_at, input int rst_at,
                           output int first_done, output int n_done, output int n_busy);
    first_done = -1; n_done = 0; n_busy = 0;
    @(negedge CLK);
    drive_inputs();
    TICK = 1'b1;
    @(negedge CLK);
    TICK = 1'b0;
    check("busy_after_tick", 32'(BUSY), 32'd1);
    for (int c = 1; c <= ncyc; c++) begin
      TICK = (c == tick2_at);
      RST  = (c == rst_at);
      if (c == chg_at) begin
        for (int k = 0; k < CH; k++) begin
          INSTR[k*IW +: IW] = 7'($urandom_range(0, 127));
          PTR[k*PW +: PW]   = 10'($urandom_range(0, 1023));
        end
        MUTE = ~MUTE;
      end
      @(negedge CLK);
      if (BUSY) n_busy++;
      if (DONE) begin
        n_done++;
        if (first_done < 0) first_done = c;
      end
      if (stop_on_done && DONE) break;
    end
    TICK = 1'b0;
    RST  = 1'b0;
  endtask

  task automatic check_values(input string tag);
    for (int k = 0; k < CH; k++)
      check($sformatf("%s_ch%0d", tag, k), 32'(VALUES[k*OW +: OW]), 32'(exp_v[k]));
  endtask

  initial begin
    int fd, nd, nb;

    for (int i = 0; i < DEPTH; i++) set_wave(i, 8'($urandom_range(0, 255)));
    for (int i = 0; i < 128; i++)
      set_instr(i, $urandom_range(0, 70000), ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 1100));
    set_instr(5, 100, 496);
    set_instr(10, 3000, 0);
    set_instr(20, DEPTH - 5, 100);
    set_instr(21, 131070, 50);
    set_wave(110, 8'hA3);
    set_wave(104, 8'h5C);
    set_wave(595, 8'h7E);
    set_wave(100, 8'h11);
    set_wave(DEPTH - 1, 8'hC4);
    set_wave(1, 8'h3D);

    vecs.push_back('{ch: 3,  instr: 5,  ptr: 500,  mute: 1'b0, exp: 12'h05C});
    vecs.push_back('{ch: 4,  instr: 5,  ptr: 1000, mute: 1'b0, exp: 12'h000});
    vecs.push_back('{ch: 5,  instr: 10, ptr: 10,   mute: 1'b0, exp: 12'h000});
    vecs.push_back('{ch: 6,  instr: 5,  ptr: 10,   mute: 1'b1, exp: 12'h000});
    vecs.push_back('{ch: 7,  instr: 5,  ptr: 495,  mute: 1'b0, exp: 12'h07E});
    vecs.push_back('{ch: 8,  instr: 5,  ptr: 496,  mute: 1'b0, exp: 12'h011});
    vecs.push_back('{ch: 9,  instr: 5,  ptr: 991,  mute: 1'b0, exp: 12'h07E});
    vecs.push_back('{ch: 10, instr: 5,  ptr: 992,  mute: 1'b0, exp: 12'h000});
    vecs.push_back('{ch: 11, instr: 20, ptr: 4,    mute: 1'b0, exp: 12'h0C4});
    vecs.push_back('{ch: 12, instr: 20, ptr: 5,    mute: 1'b0, exp: 12'h000});
    vecs.push_back('{ch: 13, instr: 21, ptr: 3,    mute: 1'b0, exp: 12'h03D});

    // Reset, then idle
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    repeat (10) @(negedge CLK);
    check("idle_values", VALUES[31:0], 32'd0);
    check("idle_values_hi", 32'(VALUES[CH*OW-1:32]), 32'd0);
    check("idle_busy", 32'(BUSY), 32'd0);
    check("idle_done", 32'(DONE), 32'd0);
    check("idle_overrun", 32'(OVERRUN), 32'd0);

    // Directed vector table
    for (int k = 0; k < CH; k++) begin
      f_instr[k] = 5; f_ptr[k] = 10; f_mute[k] = 1'b0; exp_v[k] = 12'h0A3;
    end
    foreach (vecs[i]) begin
      f_instr[vecs[i].ch] = vecs[i].instr;
      f_ptr[vecs[i].ch]   = vecs[i].ptr;
      f_mute[vecs[i].ch]  = vecs[i].mute;
      exp_v[vecs[i].ch]   = vecs[i].exp;
    end
    run_frame(25, 1'b0, -1, -1, -1, fd, nd, nb);
    check("dir_latency", 32'(fd), 32'd19);
    check("dir_ndone", 32'(nd), 32'd1);
    check("dir_busy_cycles", 32'(nb), 32'd19);
    check_values("dir");
    check("dir_overrun", 32'(OVERRUN), 32'd0);

    // Overrun tick at cycle 5, inputs scrambled at cycle 2
    random_frame();
    run_frame(25, 1'b0, 2, 5, -1, fd, nd, nb);
    check("ovr_latency", 32'(fd), 32'd19);
    check("ovr_ndone", 32'(nd), 32'd1);
    check("ovr_flag", 32'(OVERRUN), 32'd1);
    check_values("ovr");

    // Reset in the middle of a frame
    random_frame();
    run_frame(25, 1'b0, -1, -1, 8, fd, nd, nb);
    check("rst_ndone", 32'(nd), 32'd0);
    check("rst_values", VALUES[31:0], 32'd0);
    check("rst_values_hi", 32'(VALUES[CH*OW-1:32]), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_overrun", 32'(OVERRUN), 32'd0);

    random_frame();
    run_frame(25, 1'b0, -1, -1, -1, fd, nd, nb);
    check("post_rst_latency", 32'(fd), 32'd19);
    check_values("post_rst");

    // Back-to-back random frames: each tick goes out right after the previous DONE cycle
    for (int f = 0; f < 50; f++) begin
      random_frame();
      run_frame(40, 1'b1, -1, -1, -1, fd, nd, nb);
      check($sformatf("rnd%0d_latency", f), 32'(fd), 32'd19);
      check_values($sformatf("rnd%0d", f));
    end
    check("rnd_overrun", 32'(OVERRUN), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
